cc_speed_ticker: RTL and testbench
==================================

// Module: cc_speed_ticker
// PURPOSE
//   Level-programmable speed timer: free-running counter that emits a 1-cycle
//   active-low tick each time it reaches the limit selected by the game level.
//   Replaces the fixed-constant speed comparator; owns its own counter.
//   Sits between the 50 MHz clock domain and the object-movement FSMs.
//   Adds start/stop control, pause, one-shot mode and glitch-free level change.
// PARAMETERS
//   SPEEDTICKER_DATAWIDTH  23       counter and limit width
//   SPEEDTICKER_LIMIT0     833333   terminal count, level 2'b00 (slowest)
//   SPEEDTICKER_LIMIT1     625000   terminal count, level 2'b01
//   SPEEDTICKER_LIMIT2     416666   terminal count, level 2'b10
//   SPEEDTICKER_LIMIT3     208333   terminal count, level 2'b11 (fastest)
//   SPEEDTICKER_TICKWIDTH  8        width of tick event counter
// PORTS
//   CC_SPEEDTICKER_CLOCK_50         in   1   system clock, rising edge
//   CC_SPEEDTICKER_RESET_InLow      in   1   async reset, active-low
//   CC_SPEEDTICKER_start_InHigh     in   1   start request (IDLE/DONE -> RUN)
//   CC_SPEEDTICKER_stop_InHigh      in   1   stop request (any -> IDLE)
//   CC_SPEEDTICKER_enable_InHigh    in   1   0 = pause, counter holds
//   CC_SPEEDTICKER_mode_InHigh      in   1   0 periodic, 1 one-shot; sampled on start
//   CC_NIVEL_data_InBus             in   2   requested level
//   CC_SPEEDTICKER_T0_OutLow        out  1   tick, low for exactly 1 cycle
//   CC_SPEEDTICKER_busy_OutHigh     out  1   1 while state is RUN
//   CC_SPEEDTICKER_level_OutBus     out  2   level currently in force
//   CC_SPEEDTICKER_ticks_OutBus     out  TW  ticks since start, wraps
// BEHAVIOUR
//   Reset (async, RESET_InLow=0): state IDLE, count 0, T0_OutLow 1, busy 0,
//     level_OutBus 2'b00, ticks 0, latched mode 0. Applies mid-period too.
//   All other updates on rising CLOCK_50; outputs registered.
//   FSM: IDLE, RUN, DONE.
//     IDLE: count 0. start=1 -> RUN; latch mode and CC_NIVEL_data_InBus;
//       ticks cleared.
//     RUN: enable=1 -> count+1. enable=0 -> count, T0 hold (T0 stays 1).
//       count==LIMIT[level] and enable=1 -> next cycle T0_OutLow=0,
//       count=0, ticks+1 (mod 2^TW), level reloaded from CC_NIVEL_data_InBus;
//       one-shot mode -> DONE, periodic -> remain RUN.
//     DONE: count 0, T0 1. start=1 -> RUN (re-latch mode, level, clear ticks).
//     stop=1 in any state -> IDLE next cycle, count 0, ticks hold.
//   Priority: stop > start > count. start while RUN is ignored.
//   Tick period = LIMIT[level]+1 enabled cycles; first tick after start is
//     LIMIT+1 enabled cycles after the cycle start is sampled.
//   Level change mid-period is not applied until the next tick boundary;
//     level_OutBus shows the active level only.
//   Limits: each LIMITn >= 1 and < 2^DATAWIDTH; the comparison uses equality,
//     and count never exceeds the active limit.
//   Tick coincident with stop: stop wins; no tick emitted, ticks unchanged.
//   busy_OutHigh = (state==RUN); low in IDLE and DONE, including while paused? no:
//     busy stays 1 while paused in RUN.
// TESTING  (bench overrides LIMIT0..3 = 3,2,1,5; TW=8)
//   Reset low mid-RUN -> T0=1, busy=0, level=0, ticks=0 same cycle
//   start, level 0, periodic -> T0 low 1 cycle every 4 clks; ticks 1,2,3..
//   level 0->3 at count 1 -> next period still 4 clks, then 6-clk periods,
//     level_OutBus changes to 3 with the tick
//   enable low 3 cycles mid-period -> tick delayed by exactly 3 cycles
//   one-shot, level 2 -> single tick 2 clks after start, then DONE, busy=0
//   stop and start same cycle as terminal count -> IDLE, no tick; 256 ticks
//     in periodic run -> ticks wraps 255->0

Source files
------------

// File: rtl/cc_speed_ticker.sv
// cc_speed_ticker
//   Level-programmable speed timer. A free-running counter advances while
//   enabled and emits a one-cycle active-low tick each time it reaches the
//   terminal count selected by the game level. It supports start/stop
//   control, pause, periodic or one-shot operation, and level changes that
//   take effect only at a tick boundary, so a period is never cut short.
//
// Ports
//   CC_SPEEDTICKER_CLOCK_50       in   system clock, rising edge
//   CC_SPEEDTICKER_RESET_InLow    in   asynchronous reset, active-low
//   CC_SPEEDTICKER_start_InHigh   in   start request (IDLE/DONE -> RUN)
//   CC_SPEEDTICKER_stop_InHigh    in   stop request (any -> IDLE), highest priority
//   CC_SPEEDTICKER_enable_InHigh  in   0 pauses the counter while in RUN
//   CC_SPEEDTICKER_mode_InHigh    in   0 periodic, 1 one-shot; sampled on start
//   CC_NIVEL_data_InBus           in   requested level
//   CC_SPEEDTICKER_T0_OutLow      out  tick, low for exactly one cycle
//   CC_SPEEDTICKER_busy_OutHigh   out  high while in RUN (also while paused)
//   CC_SPEEDTICKER_level_OutBus   out  level currently in force
//   CC_SPEEDTICKER_ticks_OutBus   out  ticks since the last start, wraps
module cc_speed_ticker #(
  parameter int unsigned SPEEDTICKER_DATAWIDTH = 23,
  parameter int unsigned SPEEDTICKER_LIMIT0    = 833333,
  parameter int unsigned SPEEDTICKER_LIMIT1    = 625000,
  parameter int unsigned SPEEDTICKER_LIMIT2    = 416666,
  parameter int unsigned SPEEDTICKER_LIMIT3    = 208333,
  parameter int unsigned SPEEDTICKER_TICKWIDTH = 8
) (
  input  logic                             CC_SPEEDTICKER_CLOCK_50,
  input  logic                             CC_SPEEDTICKER_RESET_InLow,
  input  logic                             CC_SPEEDTICKER_start_InHigh,
  input  logic                             CC_SPEEDTICKER_stop_InHigh,
  input  logic                             CC_SPEEDTICKER_enable_InHigh,
  input  logic                             CC_SPEEDTICKER_mode_InHigh,
  input  logic [1:0]                       CC_NIVEL_data_InBus,
  output logic                             CC_SPEEDTICKER_T0_OutLow,
  output logic                             CC_SPEEDTICKER_busy_OutHigh,
  output logic [1:0]                       CC_SPEEDTICKER_level_OutBus,
  output logic [SPEEDTICKER_TICKWIDTH-1:0] CC_SPEEDTICKER_ticks_OutBus
);

  typedef enum logic [1:0] {
    stateIdle = 2'b00,
    stateRun  = 2'b01,
    stateDone = 2'b10
  } stateT;

  localparam logic [SPEEDTICKER_DATAWIDTH-1:0] limit0 = SPEEDTICKER_DATAWIDTH'(SPEEDTICKER_LIMIT0);
  localparam logic [SPEEDTICKER_DATAWIDTH-1:0] limit1 = SPEEDTICKER_DATAWIDTH'(SPEEDTICKER_LIMIT1);
  localparam logic [SPEEDTICKER_DATAWIDTH-1:0] limit2 = SPEEDTICKER_DATAWIDTH'(SPEEDTICKER_LIMIT2);
  localparam logic [SPEEDTICKER_DATAWIDTH-1:0] limit3 = SPEEDTICKER_DATAWIDTH'(SPEEDTICKER_LIMIT3);

  stateT                             state;
  logic [SPEEDTICKER_DATAWIDTH-1:0]  count;
  logic [SPEEDTICKER_DATAWIDTH-1:0]  activeLimit;
  logic                              terminal;
  logic                              modeLatched;
  logic                              tickN;
  logic                              busy;
  logic [1:0]                        level;
  logic [SPEEDTICKER_TICKWIDTH-1:0]  ticks;

  // Limit follows the level in force, not the requested one, so a level
  // request only matters at the tick boundary where it gets reloaded.
  always_comb begin
    activeLimit = limit0;
    case (level)
      2'b00:   activeLimit = limit0;
      2'b01:   activeLimit = limit1;
      2'b10:   activeLimit = limit2;
      default: activeLimit = limit3;
    endcase
  end

  assign terminal = (count == activeLimit);

  always_ff @(posedge CC_SPEEDTICKER_CLOCK_50 or negedge CC_SPEEDTICKER_RESET_InLow) begin
    if (!CC_SPEEDTICKER_RESET_InLow) begin
      state       <= stateIdle;
      count       <= '0;
      modeLatched <= 1'b0;
      tickN       <= 1'b1;
      busy        <= 1'b0;
      level       <= 2'b00;
      ticks       <= '0;
    end else begin
      // Tick is a single-cycle pulse; it is released every cycle unless the
      // terminal branch below asserts it again.
      tickN <= 1'b1;
      if (CC_SPEEDTICKER_stop_InHigh) begin
        // Stop wins even over a coincident terminal count: no tick, ticks hold.
        state <= stateIdle;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          stateIdle, stateDone: begin
            count <= '0;
            if (CC_SPEEDTICKER_start_InHigh) begin
              state       <= stateRun;
              busy        <= 1'b1;
              modeLatched <= CC_SPEEDTICKER_mode_InHigh;
              level       <= CC_NIVEL_data_InBus;
              ticks       <= '0;
            end
          end
          stateRun: begin
            if (CC_SPEEDTICKER_enable_InHigh) begin
              if (terminal) begin
                tickN <= 1'b0;
                count <= '0;
                ticks <= ticks + 1'b1;
                level <= CC_NIVEL_data_InBus;
                if (modeLatched) begin
                  state <= stateDone;
                  busy  <= 1'b0;
                end
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          default: begin
            state <= stateIdle;
            count <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign CC_SPEEDTICKER_T0_OutLow    = tickN;
  assign CC_SPEEDTICKER_busy_OutHigh = busy;
  assign CC_SPEEDTICKER_level_OutBus = level;
  assign CC_SPEEDTICKER_ticks_OutBus = ticks;

endmodule

// File: tb/tb_cc_speed_ticker.sv
// Testbench for cc_speed_ticker with small limits (3,2,1,5) and 8-bit tick
// counter. Stimulus is applied one clock at a time; a reference model that
// counts enabled cycles per period pushes expected per-cycle outputs and tick
// events into queues, and an independent monitor on the falling edge pops
// and compares them against the DUT.
module tb_cc_speed_ticker;

  localparam int unsigned L0 = 3;
  localparam int unsigned L1 = 2;
  localparam int unsigned L2 = 1;
  localparam int unsigned L3 = 5;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic          stop;
  logic          enable;
  logic          mode;
  logic [1:0]    nivel;
  logic          t0n;
  logic          busy;
  logic [1:0]    levelOut;
  logic [TW-1:0] ticksOut;

  always #10 clk = ~clk;

  cc_speed_ticker #(
    .SPEEDTICKER_DATAWIDTH(23),
    .SPEEDTICKER_LIMIT0(L0),
    .SPEEDTICKER_LIMIT1(L1),
    .SPEEDTICKER_LIMIT2(L2),
    .SPEEDTICKER_LIMIT3(L3),
    .SPEEDTICKER_TICKWIDTH(TW)
  ) dut (
    .CC_SPEEDTICKER_CLOCK_50(clk),
    .CC_SPEEDTICKER_RESET_InLow(rstN),
    .CC_SPEEDTICKER_start_InHigh(start),
    .CC_SPEEDTICKER_stop_InHigh(stop),
    .CC_SPEEDTICKER_enable_InHigh(enable),
    .CC_SPEEDTICKER_mode_InHigh(mode),
    .CC_NIVEL_data_InBus(nivel),
    .CC_SPEEDTICKER_T0_OutLow(t0n),
    .CC_SPEEDTICKER_busy_OutHigh(busy),
    .CC_SPEEDTICKER_level_OutBus(levelOut),
    .CC_SPEEDTICKER_ticks_OutBus(ticksOut)
  );

  typedef struct {
    int unsigned   edgeIdx;
    logic          t0;
    logic          busy;
    logic [1:0]    lvl;
    logic [TW-1:0] ticks;
  } expT;

  expT         expQ[$];
  int unsigned tickQ[$];

  int          checks   = 0;
  int          failures = 0;
  int unsigned edgeCnt  = 0;

  // Reference model: a run is a sequence of periods, each LIMIT[level]+1
  // enabled cycles long; the tick lands on the edge that completes a period.
  bit            mRun;
  bit            mOneShot;
  logic [1:0]    mLvl;
  logic [TW-1:0] mTicks;
  int unsigned   mElapsed;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edgeCnt);
    end
  endtask

  function automatic int unsigned lim(input logic [1:0] l);
    case (l)
      2'd0:    return L0;
      2'd1:    return L1;
      2'd2:    return L2;
      default: return L3;
    endcase
  endfunction

  task automatic modelReset();
    mRun     = 1'b0;
    mOneShot = 1'b0;
    mLvl     = 2'd0;
    mTicks   = '0;
    mElapsed = 0;
    expQ.delete();
    tickQ.delete();
  endtask

  // Called just after a rising edge: drives inputs for the next edge, predicts
  // the outputs that edge will produce, then advances to just past it.
  task automatic step(input bit st, input bit sp, input bit en, input bit md, input int lv);
    expT e;
    start  = st;
    stop   = sp;
    enable = en;
    mode   = md;
    nivel  = 2'(lv);
    e.t0   = 1'b1;
    if (sp) begin
      mRun     = 1'b0;
      mElapsed = 0;
    end else if (!mRun) begin
      if (st) begin
        mRun     = 1'b1;
        mOneShot = md;
        mLvl     = 2'(lv);
        mTicks   = '0;
        mElapsed = 0;
      end
    end else if (en) begin
      mElapsed++;
      if (mElapsed == lim(mLvl) + 1) begin
        e.t0     = 1'b0;
        mTicks   = mTicks + 1'b1;
        mLvl     = 2'(lv);
        mElapsed = 0;
        if (mOneShot) mRun = 1'b0;
        tickQ.push_back(edgeCnt + 1);
      end
    end
    e.edgeIdx = edgeCnt + 1;
    e.busy    = mRun;
    e.lvl     = mLvl;
    e.ticks   = mTicks;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_t0"}, int'(t0n), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_level"}, int'(levelOut), 0);
    check({tag, "_ticks"}, int'(ticksOut), 0);
  endtask

  // Monitor: tick events are checked whenever the DUT drives T0 low, and the
  // full output set is compared against the prediction for this edge.
  always @(negedge clk) begin
    expT e;
    if (t0n === 1'b0) begin
      check("tick_expected", (tickQ.size() != 0 && tickQ[0] == edgeCnt) ? 1 : 0, 1);
      if (tickQ.size() != 0 && tickQ[0] == edgeCnt) void'(tickQ.pop_front());
    end else if (tickQ.size() != 0 && tickQ[0] == edgeCnt) begin
      check("tick_missing", int'(t0n), 0);
      void'(tickQ.pop_front());
    end
    if (expQ.size() != 0 && expQ[0].edgeIdx == edgeCnt) begin
      e = expQ.pop_front();
      check("outputs{t0,busy,lvl,ticks}", int'({t0n, busy, levelOut, ticksOut}),
            int'({e.t0, e.busy, e.lvl, e.ticks}));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN   = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    enable = 1'b0;
    mode   = 1'b0;
    nivel  = 2'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkReset("por");
    rstN = 1'b1;

    // Periodic run at level 0: tick every 4 clocks.
    step(1, 0, 1, 0, 0);
    repeat (14) step(0, 0, 1, 0, 0);

    // Request level 3 at count 1: current period keeps level 0 timing.
    for (int i = 0; i < 8 && mElapsed != 1; i++) step(0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 1, 0, 3);

    // Pause for 3 cycles mid-period.
    for (int i = 0; i < 8 && mElapsed != 2; i++) step(0, 0, 1, 0, 3);
    repeat (3) step(0, 0, 0, 0, 3);
    repeat (12) step(0, 0, 1, 0, 3);

    // One-shot at level 2: single tick, then DONE.
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 2);
    repeat (6) step(0, 0, 1, 1, 2);

    // Restart from DONE, then stop+start on the terminal-count cycle.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 10 && mElapsed != lim(mLvl); i++) step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    repeat (8) step(0, 0, 1, 0, 1);

    // Randomised traffic.
    repeat (400)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 3)));

    // Asynchronous reset in the middle of a run.
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    repeat (4) step(0, 0, 1, 0, 1);
    check("busy_before_reset", int'(busy), int'(mRun));
    #3;
    rstN = 1'b0;
    #1;
    checkReset("midrun");
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Tick counter wrap: level 2 ticks every 2 clocks, run past 256 ticks.
    step(1, 0, 1, 0, 2);
    repeat (530) step(0, 0, 1, 0, 2);

    step(0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drain", expQ.size() + tickQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
